// File: rtl/serv_mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on a 32-bit Wishbone classic slave, registered mtip level.
// Optional tick prescaler (ctrl.DIV) is built only when SERV_MTIMER_PRESCALER_EN is defined.
module serv_mtimer #(
    parameter int PRESCALE_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [2:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_mtip
);

    localparam logic [31:0] DIV_FIELD = 32'(((64'd1 << PRESCALE_W) - 64'd1) << 8);

    logic [63:0] mtime_reg, mtime_next;
    logic [63:0] mtimecmp_reg, mtimecmp_next;
    logic [31:0] shadow_reg;
    logic [31:0] rdata_next;
    logic [31:0] ctrl_rdata;
    logic [31:0] sel_mask;
    logic        en_reg, en_next;
    logic        tick;
    logic        wb_req, wb_wr, wb_rd;

    // A request is accepted only on the edge that raises ack.
    assign wb_req = i_wb_cyc & ~o_wb_ack;
    assign wb_wr  = wb_req & i_wb_we;
    assign wb_rd  = wb_req & ~i_wb_we;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sel
            assign sel_mask[gi*8 +: 8] = {8{i_wb_sel[gi]}};
        end
    endgenerate

    // A write to either mtime half replaces the increment for that cycle.
    always_comb begin
        mtime_next    = mtime_reg + 64'(tick);
        mtimecmp_next = mtimecmp_reg;
        en_next       = en_reg;
        if (wb_wr) begin
            case (i_wb_adr)
                3'd0: mtime_next = {mtime_reg[63:32],
                                    (mtime_reg[31:0] & ~sel_mask) | (i_wb_dat & sel_mask)};
                3'd1: mtime_next = {(mtime_reg[63:32] & ~sel_mask) | (i_wb_dat & sel_mask),
                                    mtime_reg[31:0]};
                3'd2: mtimecmp_next = {mtimecmp_reg[63:32],
                                       (mtimecmp_reg[31:0] & ~sel_mask) | (i_wb_dat & sel_mask)};
                3'd3: mtimecmp_next = {(mtimecmp_reg[63:32] & ~sel_mask) | (i_wb_dat & sel_mask),
                                       mtimecmp_reg[31:0]};
                3'd4: if (i_wb_sel[0]) en_next = i_wb_dat[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_next = '0;
        case (i_wb_adr)
            3'd0:    rdata_next = mtime_reg[31:0];
            3'd1:    rdata_next = shadow_reg;
            3'd2:    rdata_next = mtimecmp_reg[31:0];
            3'd3:    rdata_next = mtimecmp_reg[63:32];
            3'd4:    rdata_next = ctrl_rdata;
            default: rdata_next = '0;
        endcase
    end

`ifdef SERV_MTIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] div_reg, div_next;
    logic [PRESCALE_W-1:0] presc_reg, presc_next;
    logic [PRESCALE_W-1:0] div_sel;
    logic                  div_wr;

    assign div_sel  = sel_mask[8 +: PRESCALE_W];
    assign div_wr   = wb_wr && (i_wb_adr == 3'd4) && (|div_sel);
    assign div_next = div_wr ? ((div_reg & ~div_sel) | (i_wb_dat[8 +: PRESCALE_W] & div_sel))
                             : div_reg;
    assign tick     = en_reg && (presc_reg == div_reg);
    assign ctrl_rdata = ({31'd0, en_reg} | (32'(div_reg) << 8)) & (DIV_FIELD | 32'd1);

    always_comb begin
        presc_next = presc_reg;
        if (div_wr || tick) begin
            presc_next = '0;
        end else if (en_reg) begin
            presc_next = presc_reg + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_reg   <= '0;
            presc_reg <= '0;
        end else begin
            div_reg   <= div_next;
            presc_reg <= presc_next;
        end
    end
`else
    assign tick       = en_reg;
    assign ctrl_rdata = {31'd0, en_reg} & ~DIV_FIELD;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime_reg    <= '0;
            mtimecmp_reg <= '1;
            shadow_reg   <= '0;
            en_reg       <= 1'b1;
            o_wb_ack     <= 1'b0;
            o_wb_dat     <= '0;
            o_mtip       <= 1'b0;
        end else begin
            mtime_reg    <= mtime_next;
            mtimecmp_reg <= mtimecmp_next;
            en_reg       <= en_next;
            o_wb_ack     <= i_wb_cyc & ~o_wb_ack;
            o_mtip       <= (mtime_reg >= mtimecmp_reg);
            if (wb_rd) begin
                o_wb_dat <= rdata_next;
                // Latch the high half so a following hi read is coherent with this lo read.
                if (i_wb_adr == 3'd0) shadow_reg <= mtime_reg[63:32];
            end
        end
    end

endmodule

// File: tb/tb_serv_mtimer.sv
// Directed self-checking bench for serv_mtimer; works with or without SERV_MTIMER_PRESCALER_EN.
module tb_serv_mtimer;

    logic        i_clk    = 1'b0;
    logic        i_rst_n  = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_we  = 1'b0;
    logic [2:0]  i_wb_adr = 3'd0;
    logic [31:0] i_wb_dat = 32'd0;
    logic [3:0]  i_wb_sel = 4'd0;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic        o_mtip;

    int checks = 0;
    int errors = 0;

`ifdef SERV_MTIMER_PRESCALER_EN
    localparam logic [31:0] EXP_CTRL_DIV3 = 32'h0000_0301;
    localparam logic [31:0] EXP_DELTA16   = 32'd4;
`else
    localparam logic [31:0] EXP_CTRL_DIV3 = 32'h0000_0001;
    localparam logic [31:0] EXP_DELTA16   = 32'd16;
`endif

    serv_mtimer #(.PRESCALE_W(8)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wb_cyc (i_wb_cyc),
        .i_wb_we  (i_wb_we),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_sel (i_wb_sel),
        .o_wb_dat (o_wb_dat),
        .o_wb_ack (o_wb_ack),
        .o_mtip   (o_mtip)
    );

    always #5 i_clk = ~i_clk;

    // Called 1ns after an edge with ack low: request edge E, returns 1ns after E+1.
    task automatic wb_write(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
        @(posedge i_clk); #1;
        $display("wb write adr=%0d dat=%08h sel=%b ack=%0b", adr, dat, sel, o_wb_ack);
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic wb_read(input logic [2:0] adr, output logic [31:0] dat);
        i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_adr = adr; i_wb_sel = 4'hF;
        @(posedge i_clk); #1;
        dat = o_wb_dat;
        $display("wb read  adr=%0d dat=%08h ack=%0b", adr, dat, o_wb_ack);
        i_wb_cyc = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_wb_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", o_wb_ack); end
        checks++; if (o_wb_dat !== 32'd0) begin errors++; $display("FAIL reset_dat: got %08h expected 00000000", o_wb_dat); end
        checks++; if (o_mtip !== 1'b0) begin errors++; $display("FAIL reset_mtip: got %b expected 0", o_mtip); end
        i_rst_n = 1'b1;
        repeat (10) @(posedge i_clk);
        #1;
        wb_read(3'd0, d);
        checks++; if (d !== 32'd10) begin errors++; $display("FAIL idle_mtime: got %08h expected 0000000a", d); end
        wb_read(3'd4, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl: got %08h expected 00000001", d); end
        wb_write(3'd6, 32'hDEAD_BEEF, 4'hF);
        wb_read(3'd6, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %08h expected 00000000", d); end
        checks++; if (o_mtip !== 1'b0) begin errors++; $display("FAIL idle_mtip: got %b expected 0", o_mtip); end
    endtask

    task automatic test_back_to_back();
        i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_adr = 3'd4;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk); #1;
            checks++;
            if (o_wb_ack !== ((i % 2) == 0)) begin
                errors++; $display("FAIL b2b_ack[%0d]: got %b expected %b", i, o_wb_ack, (i % 2) == 0);
            end
        end
        i_wb_cyc = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_mtip();
        wb_write(3'd4, 32'h0, 4'hF);
        wb_write(3'd0, 32'h0, 4'hF);
        wb_write(3'd1, 32'h0, 4'hF);
        wb_write(3'd3, 32'h0, 4'hF);
        wb_write(3'd2, 32'd20, 4'hF);
        wb_write(3'd4, 32'h1, 4'hF);
        // mtime after enable edge A+k is k; mtip follows equality by one edge.
        for (int k = 1; k <= 25; k++) begin
            if (k > 1) begin @(posedge i_clk); #1; end
            checks++;
            if (o_mtip !== (k >= 21)) begin
                errors++; $display("FAIL mtip_rise[k=%0d]: got %b expected %b", k, o_mtip, k >= 21);
            end
        end
        i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_adr = 3'd3; i_wb_dat = 32'hFFFF_FFFF; i_wb_sel = 4'hF;
        @(posedge i_clk); #1;
        $display("wb write adr=3 dat=ffffffff sel=1111 ack=%0b", o_wb_ack);
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        checks++; if (o_mtip !== 1'b1) begin errors++; $display("FAIL mtip_after_write_edge: got %b expected 1", o_mtip); end
        @(posedge i_clk); #1;
        checks++; if (o_mtip !== 1'b0) begin errors++; $display("FAIL mtip_drop: got %b expected 0", o_mtip); end
    endtask

    task automatic test_prescaler();
        logic [31:0] d, v1, v2;
        wb_write(3'd4, 32'h0000_0301, 4'hF);
        wb_read(3'd4, d);
        checks++; if (d !== EXP_CTRL_DIV3) begin errors++; $display("FAIL ctrl_div: got %08h expected %08h", d, EXP_CTRL_DIV3); end
        wb_read(3'd0, v1);
        repeat (14) @(posedge i_clk);
        #1;
        wb_read(3'd0, v2);
        checks++;
        if ((v2 - v1) !== EXP_DELTA16) begin
            errors++; $display("FAIL presc_rate: got %0d expected %0d", v2 - v1, EXP_DELTA16);
        end
        wb_write(3'd4, 32'h1, 4'hF);
    endtask

    task automatic test_wrap();
        wb_write(3'd4, 32'h0, 4'hF);
        wb_write(3'd2, 32'hFFFF_FFFF, 4'hF);
        wb_write(3'd3, 32'hFFFF_FFFF, 4'hF);
        wb_write(3'd0, 32'hFFFF_FFFE, 4'hF);
        wb_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        wb_write(3'd4, 32'h1, 4'hF);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin @(posedge i_clk); #1; end
            checks++;
            if (o_mtip !== (k == 2)) begin
                errors++; $display("FAIL wrap_mtip[k=%0d]: got %b expected %b", k, o_mtip, k == 2);
            end
        end
    endtask

    task automatic test_atomic_read();
        logic [31:0] d;
        wb_write(3'd0, 32'd100, 4'hF);
        wb_read(3'd0, d);
        checks++; if (d !== 32'd101) begin errors++; $display("FAIL mtime_write_tick_lost: got %08h expected 00000065", d); end
        wb_write(3'd1, 32'h0, 4'hF);
        wb_write(3'd0, 32'hFFFF_FFFE, 4'hF);
        wb_read(3'd0, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL atomic_lo: got %08h expected ffffffff", d); end
        wb_read(3'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL atomic_hi_shadow: got %08h expected 00000000", d); end
        wb_read(3'd0, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL atomic_lo2: got %08h expected 00000003", d); end
        wb_read(3'd1, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL atomic_hi2: got %08h expected 00000001", d); end
    endtask

    task automatic test_byte_write_reset();
        logic [31:0] d;
        wb_write(3'd2, 32'h1234_5678, 4'hF);
        wb_write(3'd2, 32'h0000_AB00, 4'b0010);
        wb_read(3'd2, d);
        checks++; if (d !== 32'h1234_AB78) begin errors++; $display("FAIL byte_write: got %08h expected 1234ab78", d); end
        wb_read(3'd3, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL byte_write_hi: got %08h expected ffffffff", d); end
        wb_write(3'd3, 32'h0, 4'hF);
        wb_write(3'd2, 32'h0, 4'hF);
        checks++; if (o_mtip !== 1'b1) begin errors++; $display("FAIL pre_reset_mtip: got %b expected 1", o_mtip); end
        i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_adr = 3'd4;
        @(posedge i_clk); #1;
        checks++; if (o_wb_ack !== 1'b1 || o_wb_dat !== 32'h1) begin
            errors++; $display("FAIL pre_reset_ack: got ack=%b dat=%08h expected ack=1 dat=00000001", o_wb_ack, o_wb_dat);
        end
        i_rst_n = 1'b0;
        i_wb_cyc = 1'b0;
        #1;
        checks++; if (o_wb_ack !== 1'b0) begin errors++; $display("FAIL async_reset_ack: got %b expected 0", o_wb_ack); end
        checks++; if (o_wb_dat !== 32'h0) begin errors++; $display("FAIL async_reset_dat: got %08h expected 00000000", o_wb_dat); end
        checks++; if (o_mtip !== 1'b0) begin errors++; $display("FAIL async_reset_mtip: got %b expected 0", o_mtip); end
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        wb_read(3'd0, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL post_reset_mtime: got %08h expected 00000001", d); end
        wb_read(3'd2, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_reset_cmp_lo: got %08h expected ffffffff", d); end
        wb_read(3'd3, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_reset_cmp_hi: got %08h expected ffffffff", d); end
        wb_read(3'd4, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL post_reset_ctrl: got %08h expected 00000001", d); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mtip();
        test_prescaler();
        test_wrap();
        test_atomic_read();
        test_byte_write_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
